// File: rtl/stack_io_pkg.sv
// ----------------------------------------------------------------------------
// stack_io_pkg
// Constants shared by the stack processor and its memory-mapped I/O stages.
//   DATA_W_DEFAULT : width of the processor data path and of the I/O bytes
//   ADDR_OUT       : D_mem address of the output byte
//   ADDR_IN        : D_mem address of the input byte
// ----------------------------------------------------------------------------
package stack_io_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam logic [7:0] ADDR_OUT = 8'd255;
    localparam logic [7:0] ADDR_IN  = 8'd254;

endpackage : stack_io_pkg

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an explicit occupancy counter. Pops are ignored
// while empty. A push into a full FIFO is accepted only when a pop happens
// in the same cycle; otherwise it is silently refused (the caller decides
// what refusal means).
// Ports:
//   clk, rstN        : clock, asynchronous active-low reset
//   push, wr_data    : write request and data
//   pop              : read request (head removed on the edge)
//   rd_data          : current head, valid only while !empty
//   count            : occupancy 0..DEPTH
//   full, empty      : derived from count
// ----------------------------------------------------------------------------
module sync_fifo
    import stack_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap naturally on overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule : sync_fifo

// File: rtl/stack_out_port.sv
// ----------------------------------------------------------------------------
// stack_out_port
// Captures every change of the processor output byte into a FIFO and drains
// it to a consumer over valid/ready. The processor never stalls; values that
// arrive while the FIFO is full (and not popping) are dropped and recorded in
// a sticky overflow flag.
// Ports:
//   clk, rstN            : clock, asynchronous active-low reset
//   cpu_data             : processor output byte (address 255)
//   out_data, out_valid  : FIFO head and non-empty indication
//   out_ready            : consumer accepts head this cycle
//   count                : FIFO occupancy 0..DEPTH
//   overflow             : sticky, a captured value was dropped
// ----------------------------------------------------------------------------
module stack_out_port
    import stack_io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [DATA_W-1:0]      cpu_data,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    logic [DATA_W-1:0] prev_q, prev_d;
    logic              overflow_q, overflow_d;
    logic              push_evt;
    logic              fifo_full;
    logic              fifo_empty;

    // A push is any change of the output byte; rewriting the same value is
    // invisible here.
    assign push_evt = (cpu_data != prev_q);

    // prev follows cpu_data on every edge; a drop happens only when full and
    // the consumer is not freeing a slot in the same cycle.
    always_comb begin
        prev_d     = cpu_data;
        overflow_d = overflow_q;
        if (push_evt && fifo_full && !(out_ready && !fifo_empty)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prev_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstN    (rstN),
        .push    (push_evt),
        .wr_data (cpu_data),
        .pop     (out_ready),
        .rd_data (out_data),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule : stack_out_port

// File: tb/tb_stack_out_port.sv
// ----------------------------------------------------------------------------
// tb_stack_out_port
// Self-checking bench for stack_out_port with a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_stack_out_port;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rstN;
    logic [7:0] cpu_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int tests;
    int failed;

    // Reference model state
    logic [7:0] m_q[$];
    logic [7:0] m_prev;
    logic       m_ovf;
    int         m_drops;
    logic [7:0] acc_stream[$];
    logic [7:0] dut_stream[$];

    stack_out_port #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .cpu_data  (cpu_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive inputs, then advance past one rising edge.
    task automatic applyStimulus(input logic [7:0] d, input logic r);
        cpu_data  = d;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    // Model: pop first (if valid and ready), then a changed value is accepted
    // whenever there is room left after that pop, else dropped.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_q.delete();
            m_prev  = 8'h00;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (m_q.size() > 0 && out_ready) begin
                void'(m_q.pop_front());
            end
            if (cpu_data != m_prev) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(cpu_data);
                    acc_stream.push_back(cpu_data);
                end else begin
                    m_ovf = 1'b1;
                    m_drops++;
                end
            end
            m_prev = cpu_data;
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (rstN) begin
            checkOutput("model_count", 32'(count), 32'(m_q.size()));
            checkOutput("model_valid", 32'(out_valid), 32'(m_q.size() != 0));
            checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
            if (m_q.size() != 0) begin
                checkOutput("model_data", 32'(out_data), 32'(m_q[0]));
            end
        end
    end

    // Record what the consumer actually takes (inputs are stable mid-cycle).
    always @(negedge clk) begin
        if (rstN && out_valid && out_ready) begin
            dut_stream.push_back(out_data);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         changes;
        int         acc_start;
        int         dut_start;
        int         n;
        logic [7:0] v;

        tests     = 0;
        failed    = 0;
        rstN      = 1'b0;
        cpu_data  = 8'h00;
        out_ready = 1'b0;

        #3;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);

        repeat (2) @(posedge clk);
        #2;
        rstN = 1'b1;

        // First capture: visible after the next edge, no fall-through.
        cpu_data = 8'h12;
        checkOutput("t1_no_fallthrough", 32'(out_valid), 32'd0);
        applyStimulus(8'h12, 1'b0);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_data", 32'(out_data), 32'h12);
        checkOutput("t1_count", 32'(count), 32'd1);
        applyStimulus(8'h12, 1'b1);
        checkOutput("t1_drained", 32'(out_valid), 32'd0);

        // Saturate and overflow, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b0);
        end
        checkOutput("t2_count_sat", 32'(count), 32'd4);
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("t2_drain_data", 32'(out_data), 32'(i));
            applyStimulus(8'h05, 1'b1);
        end
        checkOutput("t2_empty", 32'(out_valid), 32'd0);

        // Push and pop while full.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h21 + 8'(i), 1'b0);
        end
        checkOutput("t3_full", 32'(count), 32'd4);
        applyStimulus(8'h7F, 1'b1);
        checkOutput("t3_count", 32'(count), 32'd4);
        checkOutput("t3_overflow", 32'(overflow), 32'd1);
        checkOutput("t3_head", 32'(out_data), 32'h22);
        begin
            logic [7:0] exp3 [4];
            exp3 = '{8'h22, 8'h23, 8'h24, 8'h7F};
            for (int i = 0; i < 4; i++) begin
                checkOutput("t3_drain_data", 32'(out_data), 32'(exp3[i]));
                applyStimulus(8'h7F, 1'b1);
            end
        end
        checkOutput("t3_empty", 32'(out_valid), 32'd0);

        // Held value is captured once; re-visiting a value is a new push.
        repeat (10) applyStimulus(8'h33, 1'b0);
        checkOutput("t4_held_once", 32'(count), 32'd1);
        applyStimulus(8'h44, 1'b0);
        applyStimulus(8'h33, 1'b0);
        checkOutput("t4_three", 32'(count), 32'd3);

        // Asynchronous reset in the middle of a cycle.
        checkOutput("t5_pre_overflow", 32'(overflow), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("t5_rst_count", 32'(count), 32'd0);
        checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_rst_overflow", 32'(overflow), 32'd0);
        cpu_data  = 8'h00;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        rstN = 1'b1;
        applyStimulus(8'h5A, 1'b0);
        checkOutput("t5_after_valid", 32'(out_valid), 32'd1);
        checkOutput("t5_after_data", 32'(out_data), 32'h5A);
        checkOutput("t5_after_count", 32'(count), 32'd1);

        // Empty the FIFO before the random scoreboard phase.
        n = 0;
        while (out_valid && n < 2 * DEPTH + 4) begin
            applyStimulus(8'h5A, 1'b1);
            n++;
        end
        checkOutput("t6_pre_empty", 32'(out_valid), 32'd0);
        acc_start = acc_stream.size();
        dut_start = dut_stream.size();

        changes = 0;
        while (changes < 200) begin
            v = cpu_data;
            if ($urandom_range(0, 3) != 0) begin
                v = 8'($urandom_range(0, 255));
                if (v == cpu_data) v = v + 8'd1;
                changes++;
            end
            applyStimulus(v, ($urandom_range(0, 3) == 0));
        end

        n = 0;
        while (out_valid && n < 2 * DEPTH + 4) begin
            applyStimulus(cpu_data, 1'b1);
            n++;
        end
        checkOutput("t6_drain_done", 32'(out_valid), 32'd0);
        checkOutput("t6_stream_len", 32'(dut_stream.size() - dut_start),
                    32'(acc_stream.size() - acc_start));
        if (dut_stream.size() - dut_start == acc_stream.size() - acc_start) begin
            for (int i = 0; i < acc_stream.size() - acc_start; i++) begin
                checkOutput("t6_stream_data", 32'(dut_stream[dut_start + i]),
                            32'(acc_stream[acc_start + i]));
            end
        end
        checkOutput("t6_overflow_iff_drop", 32'(overflow), 32'(m_drops > 0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_stack_out_port
